// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin sharing of one ALU between two requesters with result accumulator
module alu_op_scheduler #(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_use_acc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_use_acc,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_s,
  input  logic [WIDTH-1:0] alu_f,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);
  state_t state, state_nx;
  logic rr_ptr, gnt, any_valid, accept, capture;
  logic [2:0] lat_cnt;
  logic [3:0] sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic sel_use_acc;
  // grant selection, operand mux and next-state decode
  always_comb begin
    any_valid = req0_valid | req1_valid;
    gnt = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    accept = (state == IDLE) & any_valid;
    req0_ready = accept & ~gnt;
    req1_ready = accept & gnt;
    capture = (state == EXEC) & (lat_cnt == 3'd1);
    sel_op = gnt ? req1_op : req0_op;
    sel_a = gnt ? req1_a : req0_a;
    sel_b = gnt ? req1_b : req0_b;
    sel_use_acc = gnt ? req1_use_acc : req0_use_acc;
    state_nx = state;
    state_nx = accept ? EXEC : capture ? RESP : ((state == RESP) & resp_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // operand latch, latency countdown, result capture and response handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      acc        <= '0;
      lat_cnt    <= '0;
    end else begin
      if (accept) begin
        alu_s   <= sel_op;
        alu_b   <= sel_b;
        alu_a   <= sel_use_acc ? acc : sel_a;
        resp_id <= gnt;
        lat_cnt <= LAT_INIT;
        rr_ptr  <= ~gnt;
      end
      if (state == EXEC) lat_cnt <= lat_cnt - 3'd1;
      if (capture) begin
        resp_data  <= alu_f;
        acc        <= alu_f;
        resp_valid <= 1'b1;
      end
      if (resp_valid & resp_ready) resp_valid <= 1'b0;
    end
  end
  assign busy = (state != IDLE);
endmodule
